// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS time counter: mode encodings, BCD digit type,
// digit_en bit positions and a single-nibble BCD increment helper.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_SET_SEC = 2'b11
    } mode_e;

    localparam int unsigned DIG_SEC_LO = 0;
    localparam int unsigned DIG_SEC_HI = 1;
    localparam int unsigned DIG_MIN_LO = 2;
    localparam int unsigned DIG_MIN_HI = 3;
    localparam int unsigned DIG_HR_LO  = 4;
    localparam int unsigned DIG_HR_HI  = 5;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at {MAX_HI, MAX_LO} to 00. Advances on either a direct
// increment or an incoming carry; carry out is only raised for the carry-driven wrap.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned MAX_HI = 5,
    parameter int unsigned MAX_LO = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic carry_en,
    output bcd_t hi,
    output bcd_t lo,
    output logic carry
);

    bcd_t hi_q, lo_q;
    logic at_max;

    assign at_max = (hi_q == bcd_t'(MAX_HI)) && (lo_q == bcd_t'(MAX_LO));
    // SET-mode increments wrap silently; only the running clock propagates a carry.
    assign carry  = carry_en && at_max;
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (inc || carry_en) begin
            if (at_max) begin
                hi_q <= '0;
                lo_q <= '0;
            end else if (lo_q == 4'd9) begin
                hi_q <= bcd_inc(hi_q);
                lo_q <= '0;
            end else begin
                lo_q <= bcd_inc(lo_q);
            end
        end
    end

endmodule

// File: rtl/time_bcd_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, field setting and edit-field blink.
// Define CLOCK_12H_EN for 12-hour operation with a pm output.
module time_bcd_counter
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       inc,
    output bcd_t       sec_lo,
    output bcd_t       sec_hi,
    output bcd_t       min_lo,
    output bcd_t       min_hi,
    output bcd_t       hr_lo,
    output bcd_t       hr_hi,
    output logic [5:0] digit_en,
`ifdef CLOCK_12H_EN
    output logic       pm,
`endif
    output logic       sec_tick
);

    localparam int unsigned HalfPeriod = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned PresW      = $clog2(CLK_HZ);
    localparam int unsigned BlinkW     = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
`ifdef CLOCK_12H_EN
    localparam bcd_t HrRstHi = 4'd1;
    localparam bcd_t HrRstLo = 4'd2;
`else
    localparam bcd_t HrRstHi = 4'd0;
    localparam bcd_t HrRstLo = 4'd0;
`endif

    logic [PresW-1:0]  presc_q, presc_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              phase_q, phase_d;
    logic [1:0]        mode_q;
    logic [5:0]        digit_en_q, digit_en_d;
    logic              sec_tick_q;
    bcd_t              hr_hi_q, hr_hi_d, hr_lo_q, hr_lo_d;
`ifdef CLOCK_12H_EN
    logic              pm_q, pm_d;
`endif

    logic run, tick, inc_ok, restart, hr_step;
    logic sec_carry, min_carry;

    assign run     = (mode == MODE_RUN);
    assign tick    = run && (presc_q == PresW'(CLK_HZ - 1));
    assign inc_ok  = inc && !run;
    assign restart = (mode != mode_q) || inc_ok;
    assign hr_step = min_carry || (inc_ok && (mode == MODE_SET_HR));

    bcd_mod_counter #(
        .MAX_HI (5),
        .MAX_LO (9)
    ) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_ok && (mode == MODE_SET_SEC)),
        .carry_en (tick),
        .hi       (sec_hi),
        .lo       (sec_lo),
        .carry    (sec_carry)
    );

    bcd_mod_counter #(
        .MAX_HI (5),
        .MAX_LO (9)
    ) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_ok && (mode == MODE_SET_MIN)),
        .carry_en (sec_carry),
        .hi       (min_hi),
        .lo       (min_lo),
        .carry    (min_carry)
    );

    always_comb begin
        // Prescaler is parked at 0 outside RUN so the first tick is a full period away.
        presc_d = '0;
        if (run && !tick) begin
            presc_d = presc_q + PresW'(1);
        end

        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        phase_d     = phase_q;
        if (restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BlinkW'(HalfPeriod - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        digit_en_d = 6'b111111;
        case (mode_e'(mode))
            MODE_SET_HR: begin
                digit_en_d[DIG_HR_HI] = phase_d;
                digit_en_d[DIG_HR_LO] = phase_d;
            end
            MODE_SET_MIN: begin
                digit_en_d[DIG_MIN_HI] = phase_d;
                digit_en_d[DIG_MIN_LO] = phase_d;
            end
            MODE_SET_SEC: begin
                digit_en_d[DIG_SEC_HI] = phase_d;
                digit_en_d[DIG_SEC_LO] = phase_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        hr_hi_d = hr_hi_q;
        hr_lo_d = hr_lo_q;
`ifdef CLOCK_12H_EN
        pm_d    = pm_q;
        if (hr_step) begin
            if (hr_hi_q == 4'd1 && hr_lo_q == 4'd2) begin
                hr_hi_d = 4'd0;
                hr_lo_d = 4'd1;
            end else if (hr_hi_q == 4'd1 && hr_lo_q == 4'd1) begin
                hr_lo_d = 4'd2;
                pm_d    = ~pm_q;
            end else if (hr_lo_q == 4'd9) begin
                hr_hi_d = bcd_inc(hr_hi_q);
                hr_lo_d = 4'd0;
            end else begin
                hr_lo_d = bcd_inc(hr_lo_q);
            end
        end
`else
        if (hr_step) begin
            if (hr_hi_q == 4'd2 && hr_lo_q == 4'd3) begin
                hr_hi_d = 4'd0;
                hr_lo_d = 4'd0;
            end else if (hr_lo_q == 4'd9) begin
                hr_hi_d = bcd_inc(hr_hi_q);
                hr_lo_d = 4'd0;
            end else begin
                hr_lo_d = bcd_inc(hr_lo_q);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            mode_q      <= MODE_RUN;
            digit_en_q  <= 6'b111111;
            sec_tick_q  <= 1'b0;
            hr_hi_q     <= HrRstHi;
            hr_lo_q     <= HrRstLo;
`ifdef CLOCK_12H_EN
            pm_q        <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode;
            digit_en_q  <= digit_en_d;
            sec_tick_q  <= tick;
            hr_hi_q     <= hr_hi_d;
            hr_lo_q     <= hr_lo_d;
`ifdef CLOCK_12H_EN
            pm_q        <= pm_d;
`endif
        end
    end

    assign hr_hi    = hr_hi_q;
    assign hr_lo    = hr_lo_q;
    assign digit_en = digit_en_q;
    assign sec_tick = sec_tick_q;
`ifdef CLOCK_12H_EN
    assign pm       = pm_q;
`endif

endmodule

// File: tb/tb_time_bcd_counter.sv
// Directed bench for time_bcd_counter (CLK_HZ=10, BLINK_HZ=1) with a time/enable scoreboard
// fed by a behavioural clock model; covers 24-hour and CLOCK_12H_EN builds.
module tb_time_bcd_counter;
    import clock_pkg::*;

    localparam int unsigned CLK_HZ   = 10;
    localparam int unsigned BLINK_HZ = 1;
`ifdef CLOCK_12H_EN
    localparam int HR_RST = 12;
    localparam int HR_MAX = 11;
`else
    localparam int HR_RST = 0;
    localparam int HR_MAX = 23;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = MODE_RUN;
    logic       inc   = 1'b0;
    bcd_t       sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [5:0] digit_en;
    logic       sec_tick;
`ifdef CLOCK_12H_EN
    logic       pm;
`endif

    time_bcd_counter #(
        .CLK_HZ   (CLK_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .inc      (inc),
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .hr_lo    (hr_lo),
        .hr_hi    (hr_hi),
        .digit_en (digit_en),
`ifdef CLOCK_12H_EN
        .pm       (pm),
`endif
        .sec_tick (sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [23:0] t;
        logic [5:0]  en;
        logic        tick;
        logic        pm;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   h, m, s;
    logic pmm;

    function automatic logic [7:0] bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        h = HR_RST; m = 0; s = 0; pmm = 1'b0;
    endtask

    task automatic model_hr_inc();
`ifdef CLOCK_12H_EN
        if (h == 11) pmm = ~pmm;
        h = (h == 12) ? 1 : h + 1;
`else
        h = (h + 1) % 24;
`endif
    endtask

    task automatic model_tick();
        s = (s + 1) % 60;
        if (s == 0) begin
            m = (m + 1) % 60;
            if (m == 0) model_hr_inc();
        end
    endtask

    task automatic push(input string tag, input logic [5:0] en, input logic tick);
        exp_t e;
        e.tag  = tag;
        e.t    = {bcd2(h), bcd2(m), bcd2(s)};
        e.en   = en;
        e.tick = tick;
        e.pm   = pmm;
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t        e;
        logic [23:0] obs;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: got no entry, required one");
            return;
        end
        e   = sb.pop_front();
        obs = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};
        n_vec++;
        assert (obs === e.t) else begin
            n_err++;
            $error("FAIL %s time: got %h required %h", e.tag, obs, e.t);
        end
        n_vec++;
        assert (digit_en === e.en) else begin
            n_err++;
            $error("FAIL %s digit_en: got %b required %b", e.tag, digit_en, e.en);
        end
        n_vec++;
        assert (sec_tick === e.tick) else begin
            n_err++;
            $error("FAIL %s sec_tick: got %b required %b", e.tag, sec_tick, e.tick);
        end
`ifdef CLOCK_12H_EN
        n_vec++;
        assert (pm === e.pm) else begin
            n_err++;
            $error("FAIL %s pm: got %b required %b", e.tag, pm, e.pm);
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int field(input logic [1:0] md);
        case (md)
            MODE_SET_HR:  return h;
            MODE_SET_MIN: return m;
            default:      return s;
        endcase
    endfunction

    task automatic inc_field(input logic [1:0] md);
        inc = 1'b1;
        step();
        inc = 1'b0;
        case (md)
            MODE_SET_HR:  model_hr_inc();
            MODE_SET_MIN: m = (m + 1) % 60;
            default:      s = (s + 1) % 60;
        endcase
        push("set_inc", 6'h3f, 1'b0);
        check_one();
    endtask

    task automatic set_field(input logic [1:0] md, input int target);
        int guard;
        mode = md;
        step();
        push("mode_chg", 6'h3f, 1'b0);
        check_one();
        guard = 0;
        while (field(md) != target && guard < 100) begin
            inc_field(md);
            guard++;
        end
    endtask

    initial begin
        model_reset();

        // Reset state
        #12;
        push("reset", 6'h3f, 1'b0);
        check_one();
        #10 rst_n = 1'b1;

        // 600 RUN cycles: a tick every 10 cycles, ending at 00:01:00
        for (int i = 1; i <= 600; i++) begin
            step();
            if (i % 10 == 0) model_tick();
            push("run", 6'h3f, (i % 10 == 0));
            check_one();
        end

        // Preload the last second of the day and roll over
        set_field(MODE_SET_HR, HR_MAX);
        set_field(MODE_SET_MIN, 59);
        set_field(MODE_SET_SEC, 59);
        mode = MODE_RUN;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 10) model_tick();
            push("rollover", 6'h3f, (i == 10));
            check_one();
        end

        // Minute wrap in SET_MIN, then blink pattern of the minutes field
        set_field(MODE_SET_MIN, 59);
        inc_field(MODE_SET_MIN);
        for (int j = 1; j <= 19; j++) begin
            step();
            push("blink_min", ((j / 5) % 2 == 0) ? 6'h3f : 6'b110011, 1'b0);
            check_one();
        end

        // Interrupt the prescaler at 7, return to RUN; inc in RUN is ignored
        mode = MODE_RUN;
        for (int i = 1; i <= 7; i++) begin
            step();
            push("run_pre", 6'h3f, 1'b0);
            check_one();
        end
        mode = MODE_SET_SEC;
        for (int i = 1; i <= 3; i++) begin
            step();
            push("set_hold", 6'h3f, 1'b0);
            check_one();
        end
        mode = MODE_RUN;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) inc = 1'b1;
            step();
            inc = 1'b0;
            if (i == 10) model_tick();
            push("return", 6'h3f, (i == 10));
            check_one();
        end

        // Asynchronous reset at 12:34:56 while the seconds field is blanked
        set_field(MODE_SET_HR, 12);
        set_field(MODE_SET_MIN, 34);
        set_field(MODE_SET_SEC, 56);
        for (int j = 1; j <= 7; j++) begin
            step();
            push("blink_sec", ((j / 5) % 2 == 0) ? 6'h3f : 6'b111100, 1'b0);
            check_one();
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        push("async_rst", 6'h3f, 1'b0);
        check_one();
        mode = MODE_RUN;
        step();
        push("held_rst", 6'h3f, 1'b0);
        check_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
